// File: rtl/game_flow_controller.sv
// Breakout-style game sequencer: start, level load, serve lockout, play,
// life loss, level clear and the two terminal screens.
module game_flow_controller #(
    parameter int START_LIVES  = 3,
    parameter int LEVEL_BRICKS = 40,
    parameter int SERVE_DELAY  = 25000000,
    parameter int MAX_LEVEL    = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       ball_lost,
    input  logic       brick_hit,
    input  logic       load_done,
    output logic       load_level,
    output logic [2:0] level,
    output logic [3:0] lives,
    output logic       ball_hold,
    output logic       ball_run,
    output logic       game_over,
    output logic       game_won,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SERVE = 3'd2,
        PLAY  = 3'd3,
        LOST  = 3'd4,
        CLEAR = 3'd5,
        OVER  = 3'd6,
        WIN   = 3'd7
    } state_t;

    localparam logic [3:0]  LIVES_INIT  = 4'(START_LIVES);
    localparam logic [7:0]  BRICKS_INIT = 8'(LEVEL_BRICKS);
    localparam logic [25:0] TIMER_INIT  = 26'(SERVE_DELAY);
    localparam logic [2:0]  LAST_LEVEL  = 3'(MAX_LEVEL);

    state_t      state_q, state_d;
    logic [3:0]  lives_q, lives_d;
    logic [2:0]  level_q, level_d;
    logic [7:0]  bricks_q, bricks_d;
    logic [25:0] timer_q, timer_d;
    logic        load_level_q, load_level_d;
    logic        ball_hold_q, ball_hold_d;
    logic        ball_run_q, ball_run_d;
    logic        game_over_q, game_over_d;
    logic        game_won_q, game_won_d;

    always_comb begin
        state_d  = state_q;
        lives_d  = lives_q;
        level_d  = level_q;
        bricks_d = bricks_q;
        timer_d  = timer_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = LOAD;
                lives_d = LIVES_INIT;
                level_d = 3'd0;
            end
            LOAD: if (load_done) begin
                state_d  = SERVE;
                bricks_d = BRICKS_INIT;
                timer_d  = TIMER_INIT;
            end
            SERVE: begin
                if (start && timer_q == 26'd0) begin
                    state_d = PLAY;
                end else if (timer_q != 26'd0) begin
                    timer_d = timer_q - 26'd1;
                end
            end
            PLAY: begin
                // Clearing the last brick wins over a simultaneous ball loss.
                if (brick_hit && bricks_q == 8'd1) begin
                    state_d  = CLEAR;
                    bricks_d = 8'd0;
                end else begin
                    if (brick_hit && bricks_q != 8'd0) begin
                        bricks_d = bricks_q - 8'd1;
                    end
                    if (ball_lost) begin
                        state_d = LOST;
                    end
                end
            end
            LOST: begin
                if (lives_q <= 4'd1) begin
                    state_d = OVER;
                    lives_d = 4'd0;
                end else begin
                    state_d = SERVE;
                    lives_d = lives_q - 4'd1;
                    timer_d = TIMER_INIT;
                end
            end
            CLEAR: begin
                if (level_q == LAST_LEVEL) begin
                    state_d = WIN;
                end else begin
                    state_d = LOAD;
                    level_d = level_q + 3'd1;
                end
            end
            OVER, WIN: if (start) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so they register with it.
        load_level_d = (state_d == LOAD) && (state_q != LOAD);
        ball_hold_d  = (state_d == SERVE);
        ball_run_d   = (state_d == PLAY);
        game_over_d  = (state_d == OVER);
        game_won_d   = (state_d == WIN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            lives_q      <= 4'd0;
            level_q      <= 3'd0;
            bricks_q     <= 8'd0;
            timer_q      <= 26'd0;
            load_level_q <= 1'b0;
            ball_hold_q  <= 1'b0;
            ball_run_q   <= 1'b0;
            game_over_q  <= 1'b0;
            game_won_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            lives_q      <= lives_d;
            level_q      <= level_d;
            bricks_q     <= bricks_d;
            timer_q      <= timer_d;
            load_level_q <= load_level_d;
            ball_hold_q  <= ball_hold_d;
            ball_run_q   <= ball_run_d;
            game_over_q  <= game_over_d;
            game_won_q   <= game_won_d;
        end
    end

    assign state      = state_q;
    assign lives      = lives_q;
    assign level      = level_q;
    assign load_level = load_level_q;
    assign ball_hold  = ball_hold_q;
    assign ball_run   = ball_run_q;
    assign game_over  = game_over_q;
    assign game_won   = game_won_q;

endmodule

// File: tb/tb_game_flow_controller.sv
// Scoreboard bench for game_flow_controller: directed game scenarios followed
// by random play, checked against a dwell-time based reference model.
module tb_game_flow_controller;

    localparam int SL = 2;
    localparam int LB = 3;
    localparam int SD = 4;
    localparam int ML = 1;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       ball_lost = 1'b0;
    logic       brick_hit = 1'b0;
    logic       load_done = 1'b0;
    logic       load_level;
    logic [2:0] level;
    logic [3:0] lives;
    logic       ball_hold;
    logic       ball_run;
    logic       game_over;
    logic       game_won;
    logic [2:0] state;

    game_flow_controller #(
        .START_LIVES (SL),
        .LEVEL_BRICKS(LB),
        .SERVE_DELAY (SD),
        .MAX_LEVEL   (ML)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .ball_lost (ball_lost),
        .brick_hit (brick_hit),
        .load_done (load_done),
        .load_level(load_level),
        .level     (level),
        .lives     (lives),
        .ball_hold (ball_hold),
        .ball_run  (ball_run),
        .game_over (game_over),
        .game_won  (game_won),
        .state     (state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [14:0] exp_q[$];

    // Reference model: game phase, counters, and the cycle the phase began.
    int m_mode   = 0;
    int m_lives  = 0;
    int m_level  = 0;
    int m_bricks = 0;
    int m_enter  = 0;
    int m_n      = 0;

    task automatic model_step(input logic r, input logic s, input logic bl,
                              input logic bh, input logic ld);
        int nm;
        logic ll;
        nm = m_mode;
        if (r) begin
            nm = 0; m_lives = 0; m_level = 0; m_bricks = 0;
        end else begin
            case (m_mode)
                0: if (s) begin nm = 1; m_lives = SL; m_level = 0; end
                1: if (ld) begin nm = 2; m_bricks = LB; end
                2: if (s && (m_n - m_enter) >= SD) nm = 3;
                3: begin
                    if (bh && m_bricks == 1) nm = 5;
                    else begin
                        if (bh) m_bricks = m_bricks - 1;
                        if (bl) nm = 4;
                    end
                end
                4: if (m_lives == 1) begin nm = 6; m_lives = 0; end
                   else begin nm = 2; m_lives = m_lives - 1; end
                5: if (m_level == ML) nm = 7;
                   else begin nm = 1; m_level = m_level + 1; end
                default: if (s) nm = 0;
            endcase
        end
        if (nm != m_mode) m_enter = m_n + 1;
        m_mode = nm;
        m_n = m_n + 1;
        ll = (m_mode == 1) && (m_n == m_enter);
        exp_q.push_back({3'(m_mode), 4'(m_lives), 3'(m_level), ll,
                         m_mode == 2, m_mode == 3, m_mode == 6, m_mode == 7});
    endtask

    task automatic drive(input logic r, input logic s, input logic bl,
                         input logic bh, input logic ld);
        @(negedge clk);
        reset = r; start = s; ball_lost = bl; brick_hit = bh; load_done = ld;
        model_step(r, s, bl, bh, ld);
    endtask

    task automatic run(input int n, input logic r, input logic s, input logic bl,
                       input logic bh, input logic ld);
        for (int i = 0; i < n; i++) drive(r, s, bl, bh, ld);
    endtask

    task automatic serve_and_play();
        run(SD + 2, 0, 1, 0, 0, 0);
        run(1, 0, 0, 0, 0, 0);
    endtask

    // Monitor: compare the registered outputs just after every active edge.
    initial begin
        logic [14:0] e;
        logic [14:0] got;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                got = {state, lives, level, load_level, ball_hold, ball_run,
                       game_over, game_won};
                checks++;
                if (got !== e) begin
                    errors++;
                    $display("FAIL outputs t=%0t got state=%0d lives=%0d level=%0d flags=%b required state=%0d lives=%0d level=%0d flags=%b",
                             $time, got[14:12], got[11:8], got[7:5], got[4:0],
                             e[14:12], e[11:8], e[7:5], e[4:0]);
                end
                checks++;
                if ($countones(got[4:0]) > 1) begin
                    errors++;
                    $display("FAIL overlap t=%0t flags=%b required at most one high",
                             $time, got[4:0]);
                end
            end
        end
    end

    initial begin
        // Reset and first game start with a delayed loader.
        run(2, 1, 0, 0, 0, 0);
        run(1, 0, 1, 0, 0, 0);
        run(1, 0, 0, 0, 0, 0);
        run(1, 0, 0, 0, 0, 1);
        serve_and_play();
        // Three bricks, the last together with a ball loss.
        run(1, 0, 0, 0, 1, 0);
        run(1, 0, 0, 0, 0, 0);
        run(1, 0, 0, 0, 1, 0);
        run(1, 0, 0, 1, 1, 0);
        run(2, 0, 0, 0, 0, 0);
        run(1, 0, 0, 0, 0, 1);
        serve_and_play();
        // Lose both lives, then return to idle.
        run(1, 0, 0, 1, 0, 0);
        run(2, 0, 0, 0, 0, 0);
        serve_and_play();
        run(1, 0, 0, 1, 0, 0);
        run(2, 0, 0, 1, 1, 0);
        run(1, 0, 1, 0, 0, 0);
        // Clear both levels to win; brick_hit in WIN is ignored.
        run(1, 0, 1, 0, 0, 0);
        run(1, 0, 0, 0, 0, 1);
        serve_and_play();
        run(3, 0, 0, 0, 1, 0);
        run(2, 0, 0, 0, 0, 0);
        run(1, 0, 0, 0, 0, 1);
        serve_and_play();
        run(3, 0, 0, 0, 1, 0);
        run(2, 0, 0, 0, 1, 0);
        run(1, 0, 1, 0, 0, 0);
        // Reset in PLAY with two bricks left, and mid-LOAD.
        run(1, 0, 1, 0, 0, 0);
        run(1, 0, 0, 0, 0, 1);
        serve_and_play();
        run(1, 0, 0, 0, 1, 0);
        run(1, 1, 0, 0, 0, 0);
        run(1, 0, 1, 0, 0, 0);
        run(1, 1, 0, 0, 0, 1);
        run(2, 0, 0, 0, 0, 0);
        // Random play.
        for (int i = 0; i < 4000; i++) begin
            drive($urandom_range(0, 149) == 0,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 11) == 0,
                  $urandom_range(0, 2) == 0,
                  $urandom_range(0, 3) == 0);
        end
        @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
